// File: rtl/multicast_array_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multicast_array_controller_if
// Purpose  : Bundles the tag scan chain, the tagged input stream and the
//            per-unit delivery signals of multicast_array_controller.
// Ports    : i_program, i_scan_tag_in, o_scan_tag_out  - tag scan chain
//            i_in_valid, o_in_ready, i_in_tag, i_in_data - input stream
//            i_unit_ready, o_unit_enable, o_output_value - delivery side
//            o_busy, o_drop                              - status
//            Names are from the controller's point of view.
//            slave  : controller side
//            master : upstream bus / PE row side (testbench)
// Revision : 1.0 - initial release
// ============================================================================
interface multicast_array_controller_if #(
  parameter int NUM_UNITS     = 4,
  parameter int ADDRESS_WIDTH = 4,
  parameter int BITWIDTH      = 16
);
  logic                     i_program;
  logic [ADDRESS_WIDTH-1:0] i_scan_tag_in;
  logic [ADDRESS_WIDTH-1:0] o_scan_tag_out;
  logic                     i_in_valid;
  logic                     o_in_ready;
  logic [ADDRESS_WIDTH-1:0] i_in_tag;
  logic [BITWIDTH-1:0]      i_in_data;
  logic [NUM_UNITS-1:0]     i_unit_ready;
  logic [NUM_UNITS-1:0]     o_unit_enable;
  logic [BITWIDTH-1:0]      o_output_value;
  logic                     o_busy;
  logic                     o_drop;

  modport slave (
    input  i_program, i_scan_tag_in, i_in_valid, i_in_tag, i_in_data, i_unit_ready,
    output o_scan_tag_out, o_in_ready, o_unit_enable, o_output_value, o_busy, o_drop
  );

  modport master (
    output i_program, i_scan_tag_in, i_in_valid, i_in_tag, i_in_data, i_unit_ready,
    input  o_scan_tag_out, o_in_ready, o_unit_enable, o_output_value, o_busy, o_drop
  );
endinterface
`default_nettype wire

// File: rtl/multicast_array_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicast_array_controller
// Purpose  : Serves NUM_UNITS processing units from one shared tagged input
//            stream. Per-unit tags are loaded through a daisy-chained scan
//            path; each accepted word sits in a one-entry buffer with a
//            per-unit pending mask and is handed to each matching unit the
//            first cycle that unit is ready.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - multicast_array_controller_if.slave (scan chain, input
//                   stream, per-unit delivery, busy/drop status)
// Options  : MC_BROADCAST_EN - when defined, an all-ones input tag matches
//            every unit regardless of the programmed tags.
// Revision : 1.0 - initial release
// ============================================================================
module multicast_array_controller #(
  parameter int NUM_UNITS     = 4,
  parameter int ADDRESS_WIDTH = 4,
  parameter int BITWIDTH      = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  multicast_array_controller_if.slave bus
);

`ifdef MC_BROADCAST_EN
  localparam logic [ADDRESS_WIDTH-1:0] c_BCAST_TAG = {ADDRESS_WIDTH{1'b1}};
`endif

  logic [ADDRESS_WIDTH-1:0] r_tag [NUM_UNITS];
  logic [BITWIDTH-1:0]      r_data;
  logic [NUM_UNITS-1:0]     r_pending;
  logic                     r_drop;

  logic [NUM_UNITS-1:0]     w_match;
  logic [NUM_UNITS-1:0]     w_unit_enable;
  logic                     w_in_ready;
  logic                     w_accept;

  // Per-unit tag compare against the word offered this cycle.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_match[i] = (bus.i_in_tag == r_tag[i]);
    end
`ifdef MC_BROADCAST_EN
    if (bus.i_in_tag == c_BCAST_TAG) begin
      w_match = '1;
    end
`endif
  end

  // A new word may enter when every still-pending unit takes the old word
  // this cycle, which allows back-to-back accepts at full throughput.
  assign w_in_ready    = !bus.i_program && ((r_pending & ~bus.i_unit_ready) == '0);
  assign w_accept      = bus.i_in_valid && w_in_ready;
  assign w_unit_enable = r_pending & bus.i_unit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_tag[i] <= '0;
      end
      r_data    <= '0;
      r_pending <= '0;
      r_drop    <= 1'b0;
    end else begin
      // Scan shift: first value in ends up in the last unit after a full load.
      if (bus.i_program) begin
        r_tag[0] <= bus.i_scan_tag_in;
        for (int i = 1; i < NUM_UNITS; i++) begin
          r_tag[i] <= r_tag[i-1];
        end
      end

      // The mask is captured at accept, so later tag reprogramming cannot
      // redirect a buffered word. On accept the old mask is known to drain
      // completely this cycle, so it is simply replaced.
      if (w_accept) begin
        r_data    <= bus.i_in_data;
        r_pending <= w_match;
        r_drop    <= (w_match == '0);
      end else begin
        r_pending <= r_pending & ~bus.i_unit_ready;
        r_drop    <= 1'b0;
      end
    end
  end

  assign bus.o_scan_tag_out = r_tag[NUM_UNITS-1];
  assign bus.o_in_ready     = w_in_ready;
  assign bus.o_unit_enable  = w_unit_enable;
  assign bus.o_output_value = (|w_unit_enable) ? r_data : '0;
  assign bus.o_busy         = |r_pending;
  assign bus.o_drop         = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_multicast_array_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicast_array_controller
// Purpose  : Self-checking bench for multicast_array_controller. A shadow
//            copy of the tag chain predicts the delivery mask of each
//            accepted word; a scoreboard queue holds the expected word and
//            its remaining units, retired as deliveries appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicast_array_controller;

  localparam int c_NU = 4;
  localparam int c_AW = 4;
  localparam int c_BW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicast_array_controller_if #(.NUM_UNITS(c_NU), .ADDRESS_WIDTH(c_AW), .BITWIDTH(c_BW)) bus ();

  multicast_array_controller #(.NUM_UNITS(c_NU), .ADDRESS_WIDTH(c_AW), .BITWIDTH(c_BW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [c_BW-1:0] data;
    logic [c_NU-1:0] rem;
  } sb_t;

  sb_t             sb_q[$];
  logic [c_AW-1:0] m_tag [c_NU];
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", t, obs, exp, $time);
    end
  endtask

  function automatic logic [c_NU-1:0] model_mask(input logic [c_AW-1:0] tag);
    logic [c_NU-1:0] m;
    for (int i = 0; i < c_NU; i++) m[i] = (tag == m_tag[i]);
`ifdef MC_BROADCAST_EN
    if (tag == {c_AW{1'b1}}) m = '1;
`endif
    return m;
  endfunction

  function automatic void sb_push(input logic [c_AW-1:0] tag, input logic [c_BW-1:0] data);
    sb_t e;
    e.data = data;
    e.rem  = model_mask(tag);
    if (e.rem != '0) sb_q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < c_NU; i++) m_tag[i] = '0;
    sb_q.delete();
  endfunction

  // Delivery monitor: every strobe must belong to the oldest outstanding word.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_unit_enable != '0) begin
        if (sb_q.size() == 0) begin
          chk("deliv_unexpected", {28'd0, bus.o_unit_enable}, 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("deliv_data", {16'd0, bus.o_output_value}, {16'd0, e.data});
          chk("deliv_extra_units", {28'd0, bus.o_unit_enable & ~e.rem}, 32'd0);
          e.rem = e.rem & ~bus.o_unit_enable;
          if (e.rem != '0) sb_q.push_front(e);
        end
      end else begin
        chk("idle_output_zero", {16'd0, bus.o_output_value}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [c_AW-1:0] v);
    bus.i_program     = 1'b1;
    bus.i_scan_tag_in = v;
    @(negedge clk);
    chk("in_ready_during_program", {31'd0, bus.o_in_ready}, 32'd0);
    tick();
    for (int i = c_NU-1; i > 0; i--) m_tag[i] = m_tag[i-1];
    m_tag[0] = v;
    bus.i_program = 1'b0;
  endtask

  // Offer a word until accepted (bounded); returns in the cycle after accept.
  task automatic send(input logic [c_AW-1:0] tag, input logic [c_BW-1:0] data, input bit rnd);
    bit acc = 0;
    bus.i_in_valid = 1'b1;
    bus.i_in_tag   = tag;
    bus.i_in_data  = data;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      if (bus.o_in_ready) begin
        acc = 1;
        sb_push(tag, data);
      end
      tick();
      if (rnd) bus.i_unit_ready = 4'($urandom_range(0, 15));
    end
    bus.i_in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.i_program     = 1'b0;
    bus.i_scan_tag_in = '0;
    bus.i_in_valid    = 1'b0;
    bus.i_in_tag      = '0;
    bus.i_in_data     = '0;
    bus.i_unit_ready  = '0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.o_in_ready}, 32'd1);
    chk("rst_unit_enable", {28'd0, bus.o_unit_enable}, 32'd0);
    chk("rst_output_value", {16'd0, bus.o_output_value}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_drop", {31'd0, bus.o_drop}, 32'd0);
    chk("rst_scan_out", {28'd0, bus.o_scan_tag_out}, 32'd0);
    tick();

    // Scan chain load and pass-through
    shift(4'd3); shift(4'd2); shift(4'd1); shift(4'd0);
    @(negedge clk);
    chk("scan_out_full_row", {28'd0, bus.o_scan_tag_out}, 32'd3);
    tick();
    shift(4'd9);
    @(negedge clk);
    chk("scan_out_extra_shift", {28'd0, bus.o_scan_tag_out}, 32'd2);
    tick();
    shift(4'd3); shift(4'd2); shift(4'd1); shift(4'd0);

    // Unicast to unit 2
    bus.i_unit_ready = 4'hF;
    send(4'd2, 16'hABCD, 0);
    @(negedge clk);
    chk("uni_enable", {28'd0, bus.o_unit_enable}, 32'h4);
    chk("uni_value", {16'd0, bus.o_output_value}, 32'hABCD);
    tick();
    @(negedge clk);
    chk("uni_busy_clear", {31'd0, bus.o_busy}, 32'd0);
    tick();

    // Multicast to units 1 and 3: tags {0,5,2,5}
    shift(4'd5); shift(4'd2); shift(4'd5); shift(4'd0);
    bus.i_unit_ready = 4'b0010;
    send(4'd5, 16'h1234, 0);                 // now in cycle k+1
    @(negedge clk);
    chk("mc_k1_enable", {28'd0, bus.o_unit_enable}, 32'h2);
    chk("mc_k1_in_ready", {31'd0, bus.o_in_ready}, 32'd0);
    tick();                                  // k+2
    @(negedge clk);
    chk("mc_k2_enable", {28'd0, bus.o_unit_enable}, 32'h0);
    tick();                                  // k+3
    bus.i_unit_ready = 4'b1011;
    bus.i_in_valid   = 1'b1;
    bus.i_in_tag     = 4'd0;
    bus.i_in_data    = 16'h5555;
    @(negedge clk);
    chk("mc_k3_enable", {28'd0, bus.o_unit_enable}, 32'h8);
    chk("mc_k3_in_ready", {31'd0, bus.o_in_ready}, 32'd1);
    if (bus.o_in_ready) sb_push(4'd0, 16'h5555);
    tick();
    bus.i_in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_enable", {28'd0, bus.o_unit_enable}, 32'h1);
    chk("b2b_value", {16'd0, bus.o_output_value}, 32'h5555);
    tick();

    // Unmatched tag drops
    bus.i_unit_ready = 4'hF;
    send(4'd7, 16'h0777, 0);
    @(negedge clk);
    chk("drop_pulse", {31'd0, bus.o_drop}, 32'd1);
    chk("drop_no_enable", {28'd0, bus.o_unit_enable}, 32'd0);
    tick();
    @(negedge clk);
    chk("drop_one_cycle", {31'd0, bus.o_drop}, 32'd0);
    tick();

    // All-ones tag: broadcast when enabled, otherwise an ordinary (unmatched) tag
    send(4'hF, 16'hF00D, 0);
    @(negedge clk);
`ifdef MC_BROADCAST_EN
    chk("bcast_enable", {28'd0, bus.o_unit_enable}, 32'hF);
    chk("bcast_drop", {31'd0, bus.o_drop}, 32'd0);
`else
    chk("allones_enable", {28'd0, bus.o_unit_enable}, 32'h0);
    chk("allones_drop", {31'd0, bus.o_drop}, 32'd1);
`endif
    tick();

    // Reset mid-delivery
    bus.i_unit_ready = 4'h0;
    send(4'd5, 16'hBEEF, 0);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, bus.o_busy}, 32'd1);
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("post_rst_enable", {28'd0, bus.o_unit_enable}, 32'd0);
    tick();
    bus.i_unit_ready = 4'hF;
    @(negedge clk);
    chk("post_rst_ready_enable", {28'd0, bus.o_unit_enable}, 32'd0);
    tick();
    send(4'd0, 16'h0C0C, 0);
    @(negedge clk);
    chk("post_rst_tags_zero", {28'd0, bus.o_unit_enable}, 32'hF);
    tick();

    // Program while busy: the buffered word keeps its original mask
    bus.i_unit_ready = 4'h0;
    send(4'd0, 16'h7777, 0);
    bus.i_program     = 1'b1;
    bus.i_scan_tag_in = 4'd6;
    bus.i_unit_ready  = 4'hF;
    @(negedge clk);
    chk("prog_busy_in_ready", {31'd0, bus.o_in_ready}, 32'd0);
    chk("prog_busy_enable", {28'd0, bus.o_unit_enable}, 32'hF);
    chk("prog_busy_value", {16'd0, bus.o_output_value}, 32'h7777);
    tick();
    for (int i = c_NU-1; i > 0; i--) m_tag[i] = m_tag[i-1];
    m_tag[0] = 4'd6;
    bus.i_program = 1'b0;
    send(4'd6, 16'h6666, 0);
    @(negedge clk);
    chk("prog_shift_took", {28'd0, bus.o_unit_enable}, 32'h1);
    tick();

    // Random traffic with random readiness: tags {1,2,1,3}
    shift(4'd3); shift(4'd1); shift(4'd2); shift(4'd1);
    for (int n = 0; n < 40; n++) begin
      send(4'($urandom_range(0, 3)), 16'($urandom), 1);
    end
    bus.i_unit_ready = 4'hF;
    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
